// File: rtl/mult_pkg.sv
// Shared types and defaults for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mult_state_t;

  localparam int DEFAULT_WIDTH = 64;

endpackage : mult_pkg

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: passes the input through or returns its negation.
module cond_negate #(
  parameter int W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  logic [W-1:0] one_s;

  // Negate or pass through; wraps mod 2^W so the most negative value maps to itself.
  always_comb begin
    one_s = {{(W-1){1'b0}}, 1'b1};
    if (neg) begin
      out = ~in + one_s;
    end else begin
      out = in;
    end
  end

endmodule : cond_negate

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, sign applied once at the end.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mult_state_t          state_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [WIDTH-1:0]     acc_r;
  logic [CW-1:0]        count_r;
  logic                 neg_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  logic [WIDTH-1:0]     abs_a_s;
  logic [WIDTH-1:0]     abs_b_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH:0]       addend_s;
  logic [WIDTH:0]       sum_s;

  cond_negate #(.W(WIDTH)) u_abs_a (
    .neg (signed_op & a[WIDTH-1]),
    .in  (a),
    .out (abs_a_s)
  );

  cond_negate #(.W(WIDTH)) u_abs_b (
    .neg (signed_op & b[WIDTH-1]),
    .in  (b),
    .out (abs_b_s)
  );

  cond_negate #(.W(2*WIDTH)) u_fixup (
    .neg (neg_r),
    .in  ({acc_r, mplier_r}),
    .out (prod_fix_s)
  );

  // Partial-product add, one bit wider than the accumulator to keep the carry.
  always_comb begin
    addend_s = {(WIDTH+1){1'b0}};
    if (mplier_r[0]) begin
      addend_s = {1'b0, mcand_r};
    end else begin
      addend_s = {(WIDTH+1){1'b0}};
    end
    sum_s = {1'b0, acc_r} + addend_s;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r  <= abs_a_s;
            mplier_r <= abs_b_s;
            neg_r    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          // {acc, mplier} <= {sum, mplier} >> 1
          acc_r    <= sum_s[WIDTH:1];
          mplier_r <= {sum_s[0], mplier_r[WIDTH-1:1]};
          count_r  <= count_r + CW'(1);
          if (count_r == LAST_ITER) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          product_r <= prod_fix_s;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule : seq_multiplier

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Iterative radix-2 shift-add multiplier feeding the product input of the ALU result-select mux, the mux4_1/mux8_1 tree that picks the final ALU output. It accepts two WIDTH-bit operands on a start pulse, iterates one multiplier bit per cycle, and presents a registered 2*WIDTH-bit product with a one-cycle done pulse. It supports signed and unsigned operation; the ALU consumes product[WIDTH-1:0] for MUL and the upper half for high-word multiply.

Parameters:
WIDTH, 64, operand width in bits; product is 2*WIDTH bits; must be >= 2.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress (RUN or FIN)
done  output  1  one-cycle pulse; product valid and updated in that cycle
product  output  2*WIDTH  registered result; holds until the next completion

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset value, applied on any edge with reset=1 regardless of state: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- States: IDLE, RUN, FIN.
- IDLE: done deasserts unless it was set by the previous edge. If start=1 at edge k:
  - mcand = |a| and mplier = |b| when signed_op=1, otherwise the raw values.
  - neg = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]).
  - acc = 0, count = 0, next state RUN, busy=1 after edge k.
- RUN, edges k+1 .. k+WIDTH, one iteration per edge:
  - sum = acc + (mplier[0] ? mcand : 0), computed at WIDTH+1 bits to keep the carry.
  - {acc, mplier} <= {sum, mplier} >> 1.
  - count++. The iteration with count==WIDTH-1 moves to FIN.
- FIN, edge k+WIDTH+1:
  - product <= neg ? -{acc,mplier} : {acc,mplier}, with negation mod 2^(2*WIDTH).
  - done <= 1, busy <= 0, next state IDLE.
- Latency: done and the new product are visible in the cycle after edge k+WIDTH+1, i.e. WIDTH+1 edges after start is sampled. Throughput is one result per WIDTH+2 cycles with back-to-back starts.
- start while busy=1 is ignored; operands are not re-sampled.
- start=1 in the done cycle (state IDLE) is accepted, giving back-to-back operation. done falls on that same edge and busy rises.
- Absolute values use WIDTH-bit unsigned results. |most-negative| = 2^(WIDTH-1) is representable, so no overflow case exists.
- signed_op=0 with MSBs set: operands are treated as large unsigned values and neg=0.
- Reset mid-operation aborts immediately. No done pulse follows, and product returns to 0.
- a or b = 0 takes the full WIDTH+1 latency. There is no early termination.
- There are no X outputs after the first reset edge.

Decomposition:
- Package mult_pkg: typedef enum logic [1:0] {IDLE, RUN, FIN} mult_state_t; localparam DEFAULT_WIDTH = 64.
- One sub-module: cond_negate, parameterized width, output = neg ? ~in+1 : in. Three instances:
  - WIDTH-wide for a.
  - WIDTH-wide for b.
  - 2*WIDTH-wide for the result fixup.
- The iteration adder stays inline.

Test Plan:
1. Reset 2 cycles, then start, unsigned, a=3, b=5 -> busy=1 for 65 cycles; done high exactly one cycle at 65 edges after start; product=15; busy=0 in the done cycle.
2. Signed, a=0xFFFF_FFFF_FFFF_FFFD (-3), b=7 -> product = 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB (-21).
3. Extreme operands:
   - Unsigned a=b=0xFFFF_FFFF_FFFF_FFFF -> product = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
   - Signed a=b=0x8000_0000_0000_0000 -> product = 0x4000_0000_..._0000 (2^126).
4. Start a=2, b=2, then pulse start with a=9, b=9 at cycle 20 -> the pulse is ignored and product=4. Start a=6, b=7 asserted in the done cycle -> accepted, product=42 exactly 66 cycles after the first done.
5. Start a=5, b=5, assert reset at RUN iteration 10 -> next cycle busy=0, done=0, product=0. No done for 100 cycles. A fresh start then completes normally.
6. Signed a=0x8000_0000_0000_0000, b=1 -> product = 0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000. The same operands with signed_op=0 -> product = 0x0000_..._8000_0000_0000_0000.
